// File: rtl/parity_fifo.sv
// Synchronous FIFO that stores a parity bit with every word and checks it again on read.
// Define PARITY_FIFO_ERR_INJECT_EN to add the inj_err port, which stores an inverted parity bit on push.
module parity_fifo #(
    parameter int    WIDTH         = 32,
    parameter int    DEPTH         = 3,
    parameter string PARITY_BIT    = "MSB",
    parameter string PARITY_TYPE   = "EVEN",
    parameter int    AFULL_THRESH  = DEPTH - 1,
    parameter int    AEMPTY_THRESH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WIDTH-1:0]             s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WIDTH-1:0]             m_data,
    output logic                         m_parity_err,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         err_sticky,
`ifdef PARITY_FIFO_ERR_INJECT_EN
    input  logic                         inj_err,
`endif
    input  logic                         err_clr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam bit PAR_MSB = (PARITY_BIT == "MSB");
    localparam bit PAR_ODD = (PARITY_TYPE == "ODD");
    localparam logic [CW-1:0] AF_LEVEL = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_LEVEL = CW'(AEMPTY_THRESH);

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("parity_fifo: DEPTH must be at least 2");
        end
        if (AFULL_THRESH > DEPTH) begin : g_bad_afull
            $error("parity_fifo: AFULL_THRESH must not exceed DEPTH");
        end
        if (PARITY_BIT != "MSB" && PARITY_BIT != "LSB") begin : g_bad_pbit
            $error("parity_fifo: PARITY_BIT must be \"MSB\" or \"LSB\"");
        end
        if (PARITY_TYPE != "EVEN" && PARITY_TYPE != "ODD") begin : g_bad_ptype
            $error("parity_fifo: PARITY_TYPE must be \"EVEN\" or \"ODD\"");
        end
    endgenerate

    logic [WIDTH:0]  mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            wr_parity;
    logic [WIDTH:0]  wr_word;
    logic [WIDTH:0]  head;
    logic            stored_parity;

    function automatic logic calc_parity(input logic [WIDTH-1:0] d);
        return PAR_ODD ? ~^d : ^d;
    endfunction

    // Explicit wrap compare so non-power-of-two depths index correctly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign s_ready      = !full;
    assign m_valid      = !empty;
    assign almost_full  = (count >= AF_LEVEL);
    assign almost_empty = (count <= AE_LEVEL);
    assign push         = s_valid && s_ready;
    assign pop          = m_valid && m_ready;

`ifdef PARITY_FIFO_ERR_INJECT_EN
    assign wr_parity = calc_parity(s_data) ^ inj_err;
`else
    assign wr_parity = calc_parity(s_data);
`endif

    assign wr_word       = PAR_MSB ? {wr_parity, s_data} : {s_data, wr_parity};
    assign head          = mem[rd_ptr];
    assign m_data        = PAR_MSB ? head[WIDTH-1:0] : head[WIDTH:1];
    assign stored_parity = PAR_MSB ? head[WIDTH] : head[0];
    assign m_parity_err  = (calc_parity(m_data) != stored_parity);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Error set wins over clear so a flagged pop is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (pop && m_parity_err) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule
